counter_seq: RTL and testbench



---
 rtl/counter_seq.sv | 46 ++++
 tb/tb_counter_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq.sv
// counter_seq: unsigned up-counter with a terminal-count strobe for the SD-card read path.
// Free mode counts enable pulses; sequence mode performs one counting run per start strobe.
module counter_seq #(
    parameter int unsigned   dw  = 8,
    parameter logic [dw-1:0] max = dw'(8'h40),
    parameter bit            seq = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          start_strb,
    output logic [dw-1:0] cntr,
    output logic          strb
);

    logic [dw-1:0] r_cntr;
    logic          r_running;
    logic          w_start;
    logic          w_active;
    logic          w_at_max;

    // Free mode acts as a permanently running sequence that can never be restarted.
    assign w_start  = seq & start_strb;
    assign w_active = seq ? r_running : 1'b1;
    assign w_at_max = (r_cntr == max);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cntr    <= '0;
            r_running <= 1'b0;
        end else if (w_start) begin
            r_cntr    <= '0;
            r_running <= 1'b1;
        end else if (w_active && w_at_max) begin
            r_cntr    <= '0;
            r_running <= 1'b0;
        end else if (w_active && enable) begin
            r_cntr    <= r_cntr + dw'(1);
        end
    end

    assign cntr = r_cntr;
    assign strb = w_active & w_at_max;

endmodule

// File: tb/tb_counter_seq.sv
// Self-checking bench for counter_seq: three instances (free dw=8, sequence dw=6, sequence dw=5)
// driven by directed scenarios and random stimulus, compared against a behavioural model.
module tb_counter_seq;

    localparam int F_MAX  = 'h40;
    localparam int S6_MAX = 'h3E;
    localparam int S5_MAX = 'hD;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en_f = 1'b0, st_f = 1'b0;
    logic       en_6 = 1'b0, st_6 = 1'b0;
    logic       en_5 = 1'b0, st_5 = 1'b0;
    logic [7:0] cntr_f;
    logic [5:0] cntr_6;
    logic [4:0] cntr_5;
    logic       strb_f, strb_6, strb_5;

    counter_seq #(.dw(8), .max(8'h40), .seq(1'b0)) u_free (
        .clk(clk), .reset(reset), .enable(en_f), .start_strb(st_f),
        .cntr(cntr_f), .strb(strb_f)
    );
    counter_seq #(.dw(6), .max(6'h3E), .seq(1'b1)) u_seq6 (
        .clk(clk), .reset(reset), .enable(en_6), .start_strb(st_6),
        .cntr(cntr_6), .strb(strb_6)
    );
    counter_seq #(.dw(5), .max(5'hD), .seq(1'b1)) u_seq5 (
        .clk(clk), .reset(reset), .enable(en_5), .start_strb(st_5),
        .cntr(cntr_5), .strb(strb_5)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: count value plus "a run is in progress" flag per instance.
    int exp_f, exp_6, exp_5;
    bit run_6, run_5;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        exp_f = 0; exp_6 = 0; exp_5 = 0;
        run_6 = 1'b0; run_5 = 1'b0;
    endfunction

    task automatic seq_model(inout int cnt, inout bit run, input int mx, input bit st, input bit en);
        if (st) begin
            cnt = 0; run = 1'b1;
        end else if (run && cnt == mx) begin
            cnt = 0; run = 1'b0;
        end else if (run && en) begin
            cnt = cnt + 1;
        end
    endtask

    task automatic check_all();
        check("free_cntr", 32'(cntr_f), 32'(exp_f));
        check("free_strb", 32'(strb_f), 32'(exp_f == F_MAX));
        check("seq6_cntr", 32'(cntr_6), 32'(exp_6));
        check("seq6_strb", 32'(strb_6), 32'(run_6 && exp_6 == S6_MAX));
        check("seq5_cntr", 32'(cntr_5), 32'(exp_5));
        check("seq5_strb", 32'(strb_5), 32'(run_5 && exp_5 == S5_MAX));
    endtask

    // One clock edge: capture the inputs presented to the edge, advance the model, compare.
    task automatic step();
        bit ef = en_f, e6 = en_6, s6 = st_6, e5 = en_5, s5 = st_5;
        @(posedge clk);
        #1;
        exp_f = (exp_f == F_MAX) ? 0 : exp_f + int'(ef);
        seq_model(exp_6, run_6, S6_MAX, s6, e6);
        seq_model(exp_5, run_5, S5_MAX, s5, e5);
        check_all();
    endtask

    task automatic async_reset_pulse();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("rst_async_cntr6", 32'(cntr_6), 32'd0);
        check("rst_async_strb6", 32'(strb_6), 32'd0);
        check_all();
        #1 reset = 1'b0;
    endtask

    int pulses;
    int last_k;

    initial begin
        model_reset();
        #2;
        check_all();
        #10 reset = 1'b0;

        // Free mode: 64 enable pulses spaced 3 cycles apart.
        for (int i = 1; i <= 64; i++) begin
            en_f = 1'b1;
            step();
            check("free_pulse_cntr", 32'(cntr_f), 32'(i));
            check("free_pulse_strb", 32'(strb_f), 32'(i == 64));
            en_f = 1'b0;
            if (i < 64) begin
                step();
                step();
                check("free_hold_cntr", 32'(cntr_f), 32'(i));
            end
        end
        step();
        check("free_wrap_cntr", 32'(cntr_f), 32'd0);

        // Free mode: enable pulse coincident with the strobe cycle is lost.
        en_f = 1'b1;
        for (int i = 0; i < 64; i++) step();
        check("free_full_strb", 32'(strb_f), 32'd1);
        step();
        check("free_lost_cntr", 32'(cntr_f), 32'd0);
        check("free_lost_strb", 32'(strb_f), 32'd0);
        step();
        check("free_after_cntr", 32'(cntr_f), 32'd1);
        en_f = 1'b0;

        // Sequence mode dw=6: a single run with enable held high.
        en_6 = 1'b1;
        st_6 = 1'b1;
        for (int k = 0; k <= 70; k++) begin
            step();
            st_6 = 1'b0;
            check("seq6_run_cntr", 32'(cntr_6), (k <= 62) ? 32'(k) : 32'd0);
            check("seq6_run_strb", 32'(strb_6), 32'(k == 62));
        end

        // Retrigger from the strobe: 64 runs, one pulse every 63 cycles.
        pulses = 0;
        last_k = -1;
        for (int k = 0; k < 64 * 63; k++) begin
            st_6 = (k == 0) | strb_6;
            step();
            if (strb_6) begin
                if (last_k < 0) check("retrig_first", 32'(k), 32'd62);
                else            check("retrig_period", 32'(k - last_k), 32'd63);
                last_k = k;
                pulses++;
            end
        end
        check("retrig_pulses", 32'(pulses), 32'd64);
        st_6 = 1'b0;
        for (int k = 0; k < 64; k++) step();
        check("retrig_idle_strb", 32'(strb_6), 32'd0);

        // Sequence mode dw=5: enable low for 4 cycles mid-run stretches the run by 4.
        st_5 = 1'b1;
        en_5 = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            en_5 = !(k >= 5 && k <= 8);
            step();
            st_5 = 1'b0;
            check("seq5_stall_strb", 32'(strb_5), 32'(k == 17));
        end

        // Restart at cntr=7: strobe arrives 13 cycles after the restart edge.
        en_5 = 1'b1;
        st_5 = 1'b1;
        for (int k = 0; k <= 25; k++) begin
            step();
            st_5 = 1'b0;
            if (k == 7) begin
                check("seq5_pre_restart", 32'(cntr_5), 32'd7);
                st_5 = 1'b1;
            end
            check("seq5_restart_strb", 32'(strb_5), 32'(k == 21));
        end
        en_5 = 1'b0;

        // Asynchronous reset mid-run at cntr=0x20 aborts the run.
        en_6 = 1'b1;
        st_6 = 1'b1;
        step();
        st_6 = 1'b0;
        for (int k = 0; k < 32; k++) step();
        check("seq6_pre_reset", 32'(cntr_6), 32'h20);
        async_reset_pulse();
        for (int k = 0; k < 10; k++) step();
        check("seq6_post_reset_idle", 32'(cntr_6), 32'd0);

        // Random stimulus on all three instances, with one asynchronous reset mid-way.
        for (int i = 0; i < 3000; i++) begin
            en_f = 1'($urandom_range(0, 1));
            st_f = 1'($urandom_range(0, 1));
            en_6 = ($urandom_range(0, 3) != 0);
            st_6 = ($urandom_range(0, 99) == 0);
            en_5 = ($urandom_range(0, 2) != 0);
            st_5 = ($urandom_range(0, 29) == 0);
            step();
            if (i == 1500) async_reset_pulse();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
